// File: rtl/button_pkg.sv
// Shared definitions for the push-button conditioner: repeat FSM states,
// default 50 MHz timing constants and a parameter legality check.
package button_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } rpt_state_e;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 1_000_000;   // 20 ms
  localparam int unsigned DEF_REPEAT_DELAY    = 25_000_000;  // 0.5 s
  localparam int unsigned DEF_REPEAT_RATE     = 5_000_000;   // 0.1 s
  localparam int unsigned DEF_CNT_W           = 32;

  // Every interval needs at least two cycles and must fit in the counters.
  function automatic bit params_ok(input longint unsigned debounce,
                                   input longint unsigned delay,
                                   input longint unsigned rate,
                                   input int unsigned     cnt_w);
    longint unsigned max_v;
    max_v = debounce;
    if (delay > max_v) max_v = delay;
    if (rate > max_v) max_v = rate;
    return (debounce >= 2) && (delay >= 2) && (rate >= 2) &&
           (cnt_w >= 1) && (cnt_w < 64) && ((max_v >> cnt_w) == 0);
  endfunction

endpackage

// File: rtl/button_channel.sv
// One button channel: 2-flop synchroniser, debounce filter, registered
// press/release strobes and an auto-repeat timer FSM.
module button_channel
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  input  logic repeat_en,
  output logic level,
  output logic press,
  output logic release_o,
  output logic rpt
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST = CNT_W'(REPEAT_RATE - 1);

  logic             sync1_q, sync2_q;
  logic             s;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             rpt_q, rpt_d;
  rpt_state_e       state_q, state_d;

  assign s = ~sync2_q;

  // NOTE: every flop updates with <= so all of them sample the pre-edge
  // values; synchroniser flops reset to 1 because the pins idle high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      cnt_q     <= '0;
      tmr_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      rpt_q     <= 1'b0;
      state_q   <= ST_IDLE;
    end else begin
      sync1_q   <= btn_n;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      tmr_q     <= tmr_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      rpt_q     <= rpt_d;
      state_q   <= state_d;
    end
  end

  // NOTE: each always_comb output gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (s != level_q) begin
      if (cnt_q == DB_LAST) level_d = s;
      else                  cnt_d   = cnt_q + CNT_W'(1);
    end
    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;
  end

  // A falling level wins over a due repeat pulse.
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    rpt_d   = 1'b0;
    if (!repeat_en) begin
      state_d = ST_IDLE;
      tmr_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (press_d) begin
            state_d = ST_DELAY;
            tmr_d   = '0;
          end
        end
        ST_DELAY: begin
          if (release_d) begin
            state_d = ST_IDLE;
            tmr_d   = '0;
          end else if (tmr_q == DLY_LAST) begin
            rpt_d   = 1'b1;
            state_d = ST_REPEAT;
            tmr_d   = '0;
          end else begin
            tmr_d = tmr_q + CNT_W'(1);
          end
        end
        ST_REPEAT: begin
          if (release_d) begin
            state_d = ST_IDLE;
            tmr_d   = '0;
          end else if (tmr_q == RATE_LAST) begin
            rpt_d = 1'b1;
            tmr_d = '0;
          end else begin
            tmr_d = tmr_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          tmr_d   = '0;
        end
      endcase
    end
  end

  assign level     = level_q;
  assign press     = press_q;
  assign release_o = release_q;
  assign rpt       = rpt_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions N active-low board buttons into debounced levels and
// single-cycle press/release/auto-repeat strobes.
module button_conditioner
  import button_pkg::*;
#(
  parameter int unsigned N_BUTTONS       = 4,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BUTTONS-1:0] btn_n,
  input  logic [N_BUTTONS-1:0] repeat_en,
  output logic [N_BUTTONS-1:0] level,
  output logic [N_BUTTONS-1:0] press,
  // "release" is a reserved word, hence the suffix.
  output logic [N_BUTTONS-1:0] release_o,
  output logic [N_BUTTONS-1:0] rpt,
  output logic                 any_pressed
);

  if (!params_ok(64'(DEBOUNCE_CYCLES), 64'(REPEAT_DELAY),
                 64'(REPEAT_RATE), CNT_W)) begin : g_bad_params
    $error("button_conditioner: timing parameters below 2 or too wide for CNT_W");
  end

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
    button_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_RATE    (REPEAT_RATE),
      .CNT_W          (CNT_W)
    ) u_channel (
      .clk      (clk),
      .rst      (rst),
      .btn_n    (btn_n[i]),
      .repeat_en(repeat_en[i]),
      .level    (level[i]),
      .press    (press[i]),
      .release_o(release_o[i]),
      .rpt      (rpt[i])
    );
  end

  assign any_pressed = |level;

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner with short timing parameters:
// stimulus queues expected strobes, a monitor matches what the DUT emits.
module tb_button_conditioner;

  logic       clk;
  logic       rst;
  logic [3:0] btn_n;
  logic [3:0] repeat_en;
  logic [3:0] level, press, rel, rpt;
  logic       any_pressed;

  int cyc   = 0;
  int total = 0;
  int bad   = 0;

  typedef struct {
    int         cyc;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] rpt;
  } ev_t;

  ev_t exp_q[$];
  ev_t e;

  button_conditioner #(
    .N_BUTTONS      (4),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (8),
    .REPEAT_RATE    (3),
    .CNT_W          (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_n      (btn_n),
    .repeat_en  (repeat_en),
    .level      (level),
    .press      (press),
    .release_o  (rel),
    .rpt        (rpt),
    .any_pressed(any_pressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cyc == n during the low phase that follows rising edge n.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push(input int c, input logic [3:0] p, input logic [3:0] r, input logic [3:0] t);
    exp_q.push_back('{c, p, r, t});
  endtask

  // Return in the cycle before edge k, so a new input is sampled at edge k.
  task automatic at_edge(input int k);
    while (cyc < k - 1) @(negedge clk);
  endtask

  task automatic wait_neg(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        check("sb_missed", 32'(cyc), 32'(exp_q[0].cyc));
        void'(exp_q.pop_front());
      end
      if ((press | rel | rpt) != 4'b0) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected", {20'b0, press, rel, rpt}, 32'b0);
        end else begin
          e = exp_q.pop_front();
          check("sb_cyc",   32'(cyc), 32'(e.cyc));
          check("sb_press", {28'b0, press}, {28'b0, e.press});
          check("sb_rel",   {28'b0, rel},   {28'b0, e.rel});
          check("sb_rpt",   {28'b0, rpt},   {28'b0, e.rpt});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish (cyc %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    btn_n     = 4'hF;
    repeat_en = 4'hF;
    rst       = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_level", {28'b0, level}, 32'h0);
    check("rst_press", {28'b0, press}, 32'h0);
    check("rst_rel",   {28'b0, rel},   32'h0);
    check("rst_rpt",   {28'b0, rpt},   32'h0);
    check("rst_any",   {31'b0, any_pressed}, 32'h0);
    #1 rst = 1'b0;

    // Clean press on channel 0.
    push(15, 4'b0001, 4'b0000, 4'b0000);
    push(23, 4'b0000, 4'b0000, 4'b0001);
    push(25, 4'b0000, 4'b0001, 4'b0000);
    at_edge(10); btn_n[0] = 1'b0;
    wait_neg(14); check("t1_level_before", {28'b0, level}, 32'h0);
    wait_neg(15); check("t1_level_after",  {28'b0, level}, 32'h1);
    check("t1_any", {31'b0, any_pressed}, 32'h1);
    at_edge(20); btn_n[0] = 1'b1;
    wait_neg(25); check("t1_level_fall", {28'b0, level}, 32'h0);

    // Bounce rejection on channel 1, then a long enough press.
    push(50, 4'b0010, 4'b0000, 4'b0000);
    push(56, 4'b0000, 4'b0010, 4'b0000);
    at_edge(30); btn_n[1] = 1'b0;
    at_edge(33); btn_n[1] = 1'b1;
    at_edge(34); btn_n[1] = 1'b0;
    at_edge(37); btn_n[1] = 1'b1;
    wait_neg(40); check("t2_bounce_a", {28'b0, level}, 32'h0);
    wait_neg(44); check("t2_bounce_b", {28'b0, level}, 32'h0);
    at_edge(45); btn_n[1] = 1'b0;
    wait_neg(49); check("t2_level_before", {28'b0, level}, 32'h0);
    wait_neg(50); check("t2_level_after",  {28'b0, level}, 32'h2);
    at_edge(51); btn_n[1] = 1'b1;

    // Auto-repeat on channel 2; the repeat due on the release edge is dropped.
    push(65, 4'b0100, 4'b0000, 4'b0000);
    for (int c = 73; c <= 97; c += 3) push(c, 4'b0000, 4'b0000, 4'b0100);
    push(100, 4'b0000, 4'b0100, 4'b0000);
    at_edge(60); btn_n[2] = 1'b0;
    wait_neg(80); check("t3_level_hold", {28'b0, level}, 32'h4);
    at_edge(95); btn_n[2] = 1'b1;
    wait_neg(99);  check("t3_level_last", {28'b0, level}, 32'h4);
    wait_neg(100); check("t3_level_fall", {28'b0, level}, 32'h0);

    // Repeat disabled on channel 3; re-enabling mid-hold must not restart it.
    push(115, 4'b1000, 4'b0000, 4'b0000);
    push(150, 4'b0000, 4'b1000, 4'b0000);
    at_edge(105); repeat_en[3] = 1'b0;
    at_edge(110); btn_n[3] = 1'b0;
    at_edge(125); repeat_en[3] = 1'b1;
    at_edge(145); btn_n[3] = 1'b1;
    wait_neg(150); check("t4_level_fall", {28'b0, level}, 32'h0);

    // All channels together.
    push(165, 4'b1111, 4'b0000, 4'b0000);
    push(173, 4'b0000, 4'b0000, 4'b1111);
    push(175, 4'b0000, 4'b1111, 4'b0000);
    at_edge(160); btn_n = 4'h0;
    wait_neg(165);
    check("t5_level", {28'b0, level}, 32'hF);
    check("t5_any",   {31'b0, any_pressed}, 32'h1);
    at_edge(170); btn_n = 4'hF;
    wait_neg(176); check("t5_any_off", {31'b0, any_pressed}, 32'h0);

    // Reset while channel 0 is repeating, button kept held.
    push(195, 4'b0001, 4'b0000, 4'b0000);
    push(203, 4'b0000, 4'b0000, 4'b0001);
    push(206, 4'b0000, 4'b0000, 4'b0001);
    push(209, 4'b0000, 4'b0000, 4'b0001);
    at_edge(190); btn_n[0] = 1'b0;
    wait_neg(210);
    check("t6_level_pre", {28'b0, level}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_level", {28'b0, level}, 32'h0);
    check("t6_rst_any",   {31'b0, any_pressed}, 32'h0);
    check("t6_rst_pulse", {20'b0, press, rel, rpt}, 32'h0);
    push(218, 4'b0001, 4'b0000, 4'b0000);
    push(226, 4'b0000, 4'b0000, 4'b0001);
    push(229, 4'b0000, 4'b0000, 4'b0001);
    push(232, 4'b0000, 4'b0000, 4'b0001);
    push(233, 4'b0000, 4'b0001, 4'b0000);
    wait_neg(212);
    #1 rst = 1'b0;
    wait_neg(217); check("t6_level_before", {28'b0, level}, 32'h0);
    wait_neg(218); check("t6_level_after",  {28'b0, level}, 32'h1);
    at_edge(228); btn_n[0] = 1'b1;

    wait_neg(240);
    check("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
